// File: rtl/hub75_pkg.sv
// Shared constants and state encoding for the HUB75 bit-plane blanking timer
// and the blocks that reuse its unit timer.
package hub75_pkg;

   localparam int HUB75_N_PLANES = 8;
   localparam int HUB75_LEN_W    = 8;
   localparam int HUB75_DEAD_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEAD = 2'd1,
      ST_ON   = 2'd2
   } hub75_state_e;

endpackage

// File: rtl/hub75_bcm_blanking_if.sv
// Command/config bus between the frame scheduler (master) and the
// bit-plane blanking timer (slave).
interface hub75_bcm_blanking_if
   import hub75_pkg::*;
#(
   parameter int N_PLANES = HUB75_N_PLANES,
   parameter int LEN_W    = HUB75_LEN_W,
   parameter int DEAD_W   = HUB75_DEAD_W
) ();

   logic [N_PLANES-1:0] ctrl_plane;
   logic                ctrl_go;
   logic                ctrl_rdy;
   logic                ctrl_done;
   logic [LEN_W-1:0]    cfg_bcm_bit_len;
   logic [LEN_W-1:0]    cfg_bright_len;
   logic [DEAD_W-1:0]   cfg_dead_time;

   modport master (
      output ctrl_plane, ctrl_go, cfg_bcm_bit_len, cfg_bright_len, cfg_dead_time,
      input  ctrl_rdy, ctrl_done
   );

   modport slave (
      input  ctrl_plane, ctrl_go, cfg_bcm_bit_len, cfg_bright_len, cfg_dead_time,
      output ctrl_rdy, ctrl_done
   );

endinterface

// File: rtl/hub75_unit_timer.sv
// Base-time-unit position counter with a global-brightness PWM comparator;
// position wraps after bit_len and is held at 0 while disabled.
module hub75_unit_timer #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [LEN_W-1:0] bit_len_i,
   input  logic [LEN_W-1:0] bright_len_i,
   output logic             unit_wrap_o,
   output logic             unit_on_o
);

   logic [LEN_W-1:0] unitPos_q;
   logic [LEN_W-1:0] unitPos_d;

   assign unit_wrap_o = en_i && (unitPos_q == bit_len_i);
   assign unit_on_o   = en_i && (unitPos_q < bright_len_i);

   always_comb begin
      unitPos_d = '0;
      if (en_i && !unit_wrap_o) begin
         unitPos_d = unitPos_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         unitPos_q <= '0;
      end else begin
         unitPos_q <= unitPos_d;
      end
   end

endmodule

// File: rtl/hub75_bcm_blanking.sv
// Times one BCM bit-plane display window per go: optional dead time, then
// plane*(bit_len+1) on-cycles with per-unit brightness PWM on the blank pin.
module hub75_bcm_blanking
   import hub75_pkg::*;
#(
   parameter int N_PLANES  = HUB75_N_PLANES,
   parameter int LEN_W     = HUB75_LEN_W,
   parameter int DEAD_W    = HUB75_DEAD_W,
   parameter bit BLANK_POL = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   output logic               hub75_blank,
   hub75_bcm_blanking_if.slave ctrl
);

   hub75_state_e        state_q, state_d;
   logic [N_PLANES-1:0] planeCnt_q, planeCnt_d;
   logic [DEAD_W-1:0]   deadCnt_q, deadCnt_d;
   logic [LEN_W-1:0]    bitLen_q, bitLen_d;
   logic [LEN_W-1:0]    bright_q, bright_d;
   logic                rdy_q, rdy_d;
   logic                done_q, done_d;
   logic                blank_q, blank_d;
   logic                unitWrap;
   logic                unitOn;

   hub75_unit_timer #(
      .LEN_W(LEN_W)
   ) unitTimer (
      .clk         (clk),
      .rst         (rst),
      .en_i        (state_q == ST_ON),
      .bit_len_i   (bitLen_q),
      .bright_len_i(bright_q),
      .unit_wrap_o (unitWrap),
      .unit_on_o   (unitOn)
   );

   // rdy_q is only ever high in IDLE, so it alone qualifies go.
   always_comb begin
      state_d    = state_q;
      planeCnt_d = planeCnt_q;
      deadCnt_d  = deadCnt_q;
      bitLen_d   = bitLen_q;
      bright_d   = bright_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rdy_q && ctrl.ctrl_go) begin
               planeCnt_d = ctrl.ctrl_plane;
               deadCnt_d  = ctrl.cfg_dead_time;
               bitLen_d   = ctrl.cfg_bcm_bit_len;
               bright_d   = ctrl.cfg_bright_len;
               if (ctrl.cfg_dead_time != '0) begin
                  state_d = ST_DEAD;
               end else if (ctrl.ctrl_plane != '0) begin
                  state_d = ST_ON;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_DEAD: begin
            if (deadCnt_q <= DEAD_W'(1)) begin
               if (planeCnt_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ON;
               end
            end else begin
               deadCnt_d = deadCnt_q - 1'b1;
            end
         end
         ST_ON: begin
            if (unitWrap) begin
               if (planeCnt_q == N_PLANES'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  planeCnt_d = planeCnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      rdy_d   = (state_d == ST_IDLE);
      blank_d = unitOn ? ~BLANK_POL : BLANK_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         planeCnt_q <= '0;
         deadCnt_q  <= '0;
         bitLen_q   <= '0;
         bright_q   <= '0;
         rdy_q      <= 1'b0;
         done_q     <= 1'b0;
         blank_q    <= BLANK_POL;
      end else begin
         state_q    <= state_d;
         planeCnt_q <= planeCnt_d;
         deadCnt_q  <= deadCnt_d;
         bitLen_q   <= bitLen_d;
         bright_q   <= bright_d;
         rdy_q      <= rdy_d;
         done_q     <= done_d;
         blank_q    <= blank_d;
      end
   end

   assign hub75_blank    = blank_q;
   assign ctrl.ctrl_rdy  = rdy_q;
   assign ctrl.ctrl_done = done_q;

endmodule

// File: doc/hub75_bcm_blanking.md
Name: hub75_bcm_blanking

Overview:
- Parametrised successor to the single-plane HUB75 blanking timer.
- Times one bit-plane display window per `ctrl_go` command.
- Adds configurable counter widths, a programmable dead-time before on-time (anti-ghosting), a global-brightness PWM inside every base time unit, a `ctrl_done` pulse, and a selectable blank-pin polarity.
- Sits between the frame scheduler (which issues plane weights) and the panel OE/blank pin.

Parameters:
- N_PLANES, 8: width of `ctrl_plane`, i.e. plane weight in base units, 0..2^N_PLANES-1.
- LEN_W, 8: width of `cfg_bcm_bit_len` and `cfg_bright_len`.
- DEAD_W, 6: width of `cfg_dead_time`.
- BLANK_POL, 1: pin level that means "LEDs off"; 1 = active-high blank.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hub75_blank  out  1  registered blank/OE pin drive
- ctrl_plane  in  N_PLANES  number of base units to display
- ctrl_go  in  1  start command, accepted only while `ctrl_rdy`=1
- ctrl_rdy  out  1  idle, ready for `ctrl_go`
- ctrl_done  out  1  one-cycle pulse when a window completes
- cfg_bcm_bit_len  in  LEN_W  base unit length minus 1, in cycles
- cfg_bright_len  in  LEN_W  on-cycles per unit (0 = dark, >= bit_len+1 = full)
- cfg_dead_time  in  DEAD_W  blanked cycles between go and on-time

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named `clk` and `rst`.
- Reset, and while `rst`=1:
  - state = IDLE, all counters 0.
  - `hub75_blank` = BLANK_POL (LEDs off).
  - `ctrl_rdy` = 0, `ctrl_done` = 0.
  - `ctrl_rdy` = 1 from the first cycle after `rst` deasserts.
- States: IDLE, DEAD, ON.
  - IDLE: `ctrl_rdy`=1. On `ctrl_go`:
    - Latch `ctrl_plane`, `cfg_bcm_bit_len`, `cfg_bright_len`, `cfg_dead_time`.
    - Next state is DEAD if dead_time != 0, else ON.
    - If `ctrl_plane`=0 and dead_time=0, go straight back to IDLE and pulse `ctrl_done` on the following cycle.
  - DEAD: lasts exactly dead_time cycles, then ON. If `ctrl_plane`=0, go to IDLE instead.
  - ON: lasts exactly `ctrl_plane`*(bit_len+1) cycles, then IDLE.
- Counters in ON:
  - unit_pos counts 0..bit_len and wraps to 0.
  - plane_cnt decrements on each wrap; exit ON on the wrap when plane_cnt=1.
  - No multiplier is used.
- on_int = (state==ON) & (unit_pos < bright_len), compared unsigned at LEN_W bits.
- `hub75_blank` = registered (on_int ? ~BLANK_POL : BLANK_POL): exactly 1 cycle latency, implemented as an output register.
- `ctrl_done` is asserted the cycle state re-enters IDLE from DEAD/ON, coincident with `ctrl_rdy` rising.
- `ctrl_go` while `ctrl_rdy`=0 is ignored: no queuing, no restart.
- Config inputs changing mid-window have no effect until the next go.
- `rst` mid-window aborts immediately: blank forced off-level on the next edge, and no `ctrl_done`.
- Back-to-back operation: go in the same cycle `ctrl_done` is high is accepted, so there is zero idle gap.
- Width limits:
  - bit_len = 2^LEN_W-1 is legal (unit of 2^LEN_W cycles).
  - `ctrl_plane` max gives the longest window; no counter overflow is permitted.

Decomposition:
- Shared package `hub75_pkg`:
  - state encoding localparams (ST_IDLE, ST_DEAD, ST_ON).
  - default width constants `HUB75_LEN_W`, `HUB75_DEAD_W`.
- Sub-module `hub75_unit_timer`:
  - unit_pos wrap counter plus brightness comparator.
  - outputs unit_wrap and unit_on.
  - reusable by the future row-scan sequencer.
- The FSM and the plane counter stay in the top.

Test Plan:
- Reset:
  - Hold `rst` 3 cycles mid-window with `ctrl_plane`=5 -> `hub75_blank`=1 the cycle after `rst` is sampled, `ctrl_rdy`=0 during `rst` and 1 after, no `ctrl_done`.
- Dead-time plus full brightness:
  - Stimulus: plane=4, bit_len=3, bright=4, dead=2, go at cycle 0.
  - DEAD at cycles 1-2, ON at 3-18.
  - `hub75_blank`=0 at cycles 4-19 (16 cycles).
  - `ctrl_done` and `ctrl_rdy` high at 19.
- PWM dimming:
  - Stimulus: plane=2, bit_len=3, bright=2, dead=0, go at 0.
  - `hub75_blank`=0 only at cycles 2,3,6,7.
  - `ctrl_done` at 9.
- Edge values:
  - bright=0 -> blank never low.
  - plane=0, dead=0 -> `ctrl_done` at cycle 1 with blank always high.
  - bit_len=255, plane=1 -> exactly 256 on-cycles.
- Handshake:
  - go pulsed during ON -> ignored, window length unchanged.
  - go asserted in the `ctrl_done` cycle -> new window starts with no gap.
  - Config changed mid-window -> current timing unaffected.
- Polarity:
  - BLANK_POL=0 rerun of the dead-time test -> waveform inverted, reset level 0.
